// File: rtl/uart_rx_frame_check_if.sv
// Bundles the RX-controller strobes/config and the frame-check status outputs.
// The master modport drives strobes; the slave modport is the checker.
interface uart_rx_frame_check_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = 4
);
  logic                 data_vld;
  logic [WIDTH-1:0]     p_data;
  logic [LEN_WIDTH-1:0] data_len;
  logic                 parity_en;
  logic [1:0]           parity_mode;
  logic                 stop_two;
  logic                 bit_strb;
  logic                 sampled_bit;
  logic                 frame_abort;
  logic                 err_clr;
  logic                 frame_done;
  logic                 parity_err;
  logic                 stop_err;
  logic [CNT_WIDTH-1:0] par_err_cnt;
  logic [CNT_WIDTH-1:0] stop_err_cnt;
  logic                 err_sticky;

  modport master (
    output data_vld, p_data, data_len, parity_en, parity_mode, stop_two,
           bit_strb, sampled_bit, frame_abort, err_clr,
    input  frame_done, parity_err, stop_err, par_err_cnt, stop_err_cnt, err_sticky
  );

  modport slave (
    input  data_vld, p_data, data_len, parity_en, parity_mode, stop_two,
           bit_strb, sampled_bit, frame_abort, err_clr,
    output frame_done, parity_err, stop_err, par_err_cnt, stop_err_cnt, err_sticky
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX parity/stop-bit checker: frame-done pulse 1 cycle after the last strobe,
// saturating error counters and a sticky error summary.
module uart_rx_frame_check #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  uart_rx_frame_check_if.slave    io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_PAR, S_STOP1, S_STOP2} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_par_en;
  logic [1:0]           r_par_mode;
  logic                 r_stop_two;
  logic                 r_data_xor;
  logic                 r_par_flag, r_stop_flag;
  logic                 r_done, r_parity_err, r_stop_err, r_sticky;
  logic [CNT_WIDTH-1:0] r_par_cnt, r_stop_cnt;

  logic                 w_par_flag_nxt, w_stop_flag_nxt, w_finish;
  logic                 w_exp_par, w_data_xor;
  logic [LEN_WIDTH-1:0] w_eff_len;

  always_comb begin
    w_eff_len = io_bus.data_len;
    if (io_bus.data_len == '0 || io_bus.data_len > LEN_WIDTH'(WIDTH))
      w_eff_len = LEN_WIDTH'(WIDTH);
  end

  // Only the low eff_len bits contribute; upper bits of p_data are don't-care.
  always_comb begin
    w_data_xor = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEN_WIDTH'(i) < w_eff_len)
        w_data_xor = w_data_xor ^ io_bus.p_data[i];
    end
  end

  always_comb begin
    case (r_par_mode)
      2'b00:   w_exp_par = r_data_xor;
      2'b01:   w_exp_par = ~r_data_xor;
      2'b10:   w_exp_par = 1'b1;
      default: w_exp_par = 1'b0;
    endcase
  end

  // Priority: a new character restarts, then abort, then bit strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_par_flag_nxt  = r_par_flag;
    w_stop_flag_nxt = r_stop_flag;
    w_finish        = 1'b0;
    if (io_bus.data_vld) begin
      w_par_flag_nxt  = 1'b0;
      w_stop_flag_nxt = 1'b0;
      w_state_nxt     = io_bus.parity_en ? S_PAR : S_STOP1;
    end else if (io_bus.frame_abort) begin
      w_state_nxt = S_IDLE;
    end else if (io_bus.bit_strb) begin
      case (r_state)
        S_PAR: begin
          if (r_par_en && (io_bus.sampled_bit != w_exp_par))
            w_par_flag_nxt = 1'b1;
          w_state_nxt = S_STOP1;
        end
        S_STOP1: begin
          if (!io_bus.sampled_bit)
            w_stop_flag_nxt = 1'b1;
          if (r_stop_two) begin
            w_state_nxt = S_STOP2;
          end else begin
            w_state_nxt = S_IDLE;
            w_finish    = 1'b1;
          end
        end
        S_STOP2: begin
          if (!io_bus.sampled_bit)
            w_stop_flag_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_par_flag  <= 1'b0;
      r_stop_flag <= 1'b0;
      r_par_en    <= 1'b0;
      r_par_mode  <= 2'b00;
      r_stop_two  <= 1'b0;
      r_data_xor  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_par_flag  <= w_par_flag_nxt;
      r_stop_flag <= w_stop_flag_nxt;
      if (io_bus.data_vld) begin
        r_par_en   <= io_bus.parity_en;
        r_par_mode <= io_bus.parity_mode;
        r_stop_two <= io_bus.stop_two;
        r_data_xor <= w_data_xor;
      end
    end
  end

  // Err_clr beats a same-cycle frame update for counters and sticky only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
      r_stop_err   <= 1'b0;
      r_par_cnt    <= '0;
      r_stop_cnt   <= '0;
      r_sticky     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_parity_err <= w_par_flag_nxt;
        r_stop_err   <= w_stop_flag_nxt;
      end
      if (io_bus.err_clr) begin
        r_par_cnt  <= '0;
        r_stop_cnt <= '0;
        r_sticky   <= 1'b0;
      end else if (w_finish) begin
        if (w_par_flag_nxt && r_par_cnt != '1)
          r_par_cnt <= r_par_cnt + CNT_WIDTH'(1);
        if (w_stop_flag_nxt && r_stop_cnt != '1)
          r_stop_cnt <= r_stop_cnt + CNT_WIDTH'(1);
        if (w_par_flag_nxt || w_stop_flag_nxt)
          r_sticky <= 1'b1;
      end
    end
  end

  assign io_bus.frame_done   = r_done;
  assign io_bus.parity_err   = r_parity_err;
  assign io_bus.stop_err     = r_stop_err;
  assign io_bus.par_err_cnt  = r_par_cnt;
  assign io_bus.stop_err_cnt = r_stop_cnt;
  assign io_bus.err_sticky   = r_sticky;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Table-driven frame vectors plus corner sequences; expected results are queued
// at the final strobe and compared when frame_done appears.
module tb_uart_rx_frame_check;
  localparam int W = 8;
  localparam int C = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_check_if #(.WIDTH(W), .CNT_WIDTH(C), .LEN_WIDTH(L)) bus ();

  uart_rx_frame_check #(.WIDTH(W), .CNT_WIDTH(C), .LEN_WIDTH(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  typedef struct {
    logic       perr;
    logic       serr;
    logic [7:0] pcnt;
    logic [7:0] scnt;
    logic       sticky;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] len;
    logic       pen;
    logic [1:0] mode;
    logic       two;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic       eperr;
    logic       eserr;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  vec_t       vt[11];
  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  int         done_snap;
  logic [7:0] m_pcnt = 8'd0;
  logic [7:0] m_scnt = 8'd0;
  logic       m_sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.frame_done === 1'b1) begin
      done_seen++;
      check("done_has_expectation", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("parity_err",   32'(bus.parity_err),   32'(mon_e.perr));
        check("stop_err",     32'(bus.stop_err),     32'(mon_e.serr));
        check("par_err_cnt",  32'(bus.par_err_cnt),  32'(mon_e.pcnt));
        check("stop_err_cnt", 32'(bus.stop_err_cnt), 32'(mon_e.scnt));
        check("err_sticky",   32'(bus.err_sticky),   32'(mon_e.sticky));
      end
    end
  end

  task automatic clear_inputs();
    bus.data_vld    = 1'b0;
    bus.p_data      = '0;
    bus.data_len    = '0;
    bus.parity_en   = 1'b0;
    bus.parity_mode = 2'b00;
    bus.stop_two    = 1'b0;
    bus.bit_strb    = 1'b0;
    bus.sampled_bit = 1'b0;
    bus.frame_abort = 1'b0;
    bus.err_clr     = 1'b0;
  endtask

  task automatic strobe(input logic b);
    bus.bit_strb    = 1'b1;
    bus.sampled_bit = b;
    step();
    bus.bit_strb    = 1'b0;
    step();
  endtask

  task automatic send_frame(input vec_t v, input logic clr_end, input string name);
    logic fb;
    bus.data_vld    = 1'b1;
    bus.p_data      = v.d;
    bus.data_len    = v.len;
    bus.parity_en   = v.pen;
    bus.parity_mode = v.mode;
    bus.stop_two    = v.two;
    step();
    // Scramble config mid-frame; the checker must use the latched copy.
    bus.data_vld    = 1'b0;
    bus.frame_abort = 1'b0;
    bus.p_data      = 8'($urandom);
    bus.data_len    = 4'($urandom);
    bus.parity_en   = ~v.pen;
    bus.parity_mode = ~v.mode;
    bus.stop_two    = ~v.two;
    step();
    if (v.pen) strobe(v.pbit);
    if (v.two) begin
      strobe(v.s1);
      fb = v.s2;
    end else begin
      fb = v.s1;
    end
    if (clr_end) begin
      m_pcnt = 8'd0;
      m_scnt = 8'd0;
      m_sticky = 1'b0;
    end else begin
      if (v.eperr && m_pcnt != 8'hFF) m_pcnt = m_pcnt + 8'd1;
      if (v.eserr && m_scnt != 8'hFF) m_scnt = m_scnt + 8'd1;
      m_sticky = m_sticky | v.eperr | v.eserr;
    end
    sb_q.push_back('{perr: v.eperr, serr: v.eserr, pcnt: m_pcnt, scnt: m_scnt, sticky: m_sticky});
    bus.bit_strb    = 1'b1;
    bus.sampled_bit = fb;
    bus.err_clr     = clr_end;
    step();
    bus.bit_strb    = 1'b0;
    bus.err_clr     = 1'b0;
    check({name, "_latency"}, 32'(bus.frame_done), 32'd1);
    step();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_done"},   32'(bus.frame_done),   32'd0);
    check({name, "_perr"},   32'(bus.parity_err),   32'd0);
    check({name, "_serr"},   32'(bus.stop_err),     32'd0);
    check({name, "_pcnt"},   32'(bus.par_err_cnt),  32'd0);
    check({name, "_scnt"},   32'(bus.stop_err_cnt), 32'd0);
    check({name, "_sticky"}, 32'(bus.err_sticky),   32'd0);
  endtask

  initial begin
    //            d      len    pen   mode   two   pbit  s1    s2    eperr eserr
    vt[0]  = '{8'hA5, 4'd8,  1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{8'h83, 4'd7,  1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{8'h00, 4'd8,  1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{8'h7F, 4'd0,  1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{8'h01, 4'd15, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{8'h00, 4'd8,  1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8'h00, 4'd8,  1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{8'hE0, 4'd5,  1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{8'h00, 4'd8,  1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{8'h00, 4'd8,  1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[10] = '{8'h03, 4'd2,  1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      send_frame(vt[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Restart in PAR, then abort in STOP1 of the new frame: nothing completes.
    done_snap = done_seen;
    bus.data_vld = 1'b1; bus.parity_en = 1'b1; bus.parity_mode = 2'b00; bus.p_data = 8'h00;
    step();
    bus.data_vld = 1'b0;
    step();
    bus.data_vld = 1'b1;
    step();
    bus.data_vld = 1'b0;
    strobe(1'b1);
    bus.frame_abort = 1'b1;
    step();
    bus.frame_abort = 1'b0;
    strobe(1'b0);
    strobe(1'b0);
    step();
    check("abort_no_done", 32'(done_seen), 32'(done_snap));
    check("abort_pcnt", 32'(bus.par_err_cnt), 32'(m_pcnt));
    check("abort_scnt", 32'(bus.stop_err_cnt), 32'(m_scnt));

    // Abort and data_vld together: the new frame proceeds.
    bus.data_vld = 1'b1; bus.parity_en = 1'b1;
    step();
    bus.data_vld = 1'b0;
    step();
    bus.frame_abort = 1'b1;
    send_frame('{8'h00, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0, "abort_vs_vld");

    // Err_clr in the completing cycle of an errored frame.
    send_frame('{8'hA5, 4'd8, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b1, "clr_win");
    check("clr_win_pcnt", 32'(bus.par_err_cnt), 32'd0);
    check("clr_win_perr", 32'(bus.parity_err), 32'd1);

    // Mark-mode parity errors past the counter limit.
    for (int i = 0; i < 260; i++) begin
      send_frame('{8'($urandom), 4'd8, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}, 1'b0, "sat");
    end
    check("sat_pcnt", 32'(bus.par_err_cnt), 32'hFF);

    // Asynchronous reset mid-frame.
    bus.data_vld = 1'b1; bus.parity_en = 1'b1;
    step();
    bus.data_vld = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    m_pcnt = 8'd0; m_scnt = 8'd0; m_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    done_snap = done_seen;
    strobe(1'b0);
    strobe(1'b0);
    check("midrst_idle", 32'(done_seen), 32'(done_snap));
    send_frame(vt[1], 1'b0, "post_rst");

    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
